// File: rtl/fpu_wb_pkg.sv
// Shared types and helpers for the Wishbone front-end of the FPU register file.
package fpu_wb_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, RMW_RD, WRITE, READ, ACK} wb_state_e;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;
  localparam logic [7:0]  REG_RESULT_OFS = 8'h10;

  // Byte-lane merge: selected lanes come from the bus, the rest keep the register contents.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/fpu_wb_watchdog.sv
// Wait-state watchdog: counts while enabled, flags the last allowed WAIT cycle.
module fpu_wb_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fpu_wb_slave.sv
// Wishbone classic slave for the FPU register file: window decode, full-word writes
// (partial writes via read-modify-write) and stalling while div/sqrt is busy.
module fpu_wb_slave
  import fpu_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          ADDR_BITS   = 8,
  parameter logic [7:0]  RESULT_OFS  = REG_RESULT_OFS,
  parameter int          TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        fpu_wren,
  output logic [31:0] fpu_addr,
  output logic [31:0] fpu_wrdata,
  input  logic [31:0] fpu_rddata,
  input  logic        fpu_busy,
  input  logic        fpu_done,
  output logic        timeout
);

  wb_state_e   state, state_d;
  logic        we_q, tmo_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q, rd_q;
  logic        live, req, hit, wd_exp;

  assign live = wbs_cyc_i & wbs_stb_i;
  assign req  = live & (|wbs_sel_i);
  assign hit  = (wbs_adr_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);

  function automatic wb_state_e op_state(input logic we, input logic [3:0] sel);
    if (!we)           return READ;
    if (sel == 4'hF)   return WRITE;
    return RMW_RD;
  endfunction

  fpu_wb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != WAIT),
    .en      (state == WAIT),
    .expired (wd_exp)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (req) begin
                if (!hit)         state_d = ACK;
                else if (fpu_busy) state_d = WAIT;
                else              state_d = op_state(wbs_we_i, wbs_sel_i);
              end
      // Completion beats expiry when both land in the same cycle.
      WAIT:   if (!live)                      state_d = IDLE;
              else if (fpu_done || !fpu_busy) state_d = op_state(we_q, sel_q);
              else if (wd_exp)                state_d = ACK;
      RMW_RD: state_d = live ? WRITE : IDLE;
      WRITE:  state_d = live ? ACK : IDLE;
      READ:   state_d = live ? ACK : IDLE;
      ACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      rd_q       <= '0;
      tmo_q      <= 1'b0;
      fpu_addr   <= '0;
      fpu_wrdata <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (req) begin
          we_q  <= wbs_we_i;
          sel_q <= wbs_sel_i;
          dat_q <= wbs_dat_i;
          rd_q  <= '0;
          tmo_q <= 1'b0;
          if (hit) fpu_addr <= 32'(wbs_adr_i[ADDR_BITS-1:0]);
          if (state_d == WRITE) fpu_wrdata <= wbs_dat_i;
        end
        WAIT: begin
          if (state_d == WRITE) fpu_wrdata <= dat_q;
          if (state_d == ACK)   tmo_q <= 1'b1;
        end
        RMW_RD: fpu_wrdata <= merge_lanes(fpu_rddata, dat_q, sel_q);
        READ:   rd_q <= fpu_rddata;
        default: ;
      endcase
    end
  end

  assign wbs_ack_o = (state == ACK);
  assign wbs_dat_o = wbs_ack_o ? rd_q : '0;
  assign fpu_wren  = (state == WRITE);
  assign timeout   = wbs_ack_o & tmo_q;

endmodule
